// File: rtl/unidade_controle_multiciclo_if.sv
// Purpose: bundles the opcode/mem_ready inputs and all datapath control
//          strobes of the multi-cycle MIPS main control unit.
// Modports:
//   master - the control FSM: takes opcode and mem_ready, drives the strobes
//   slave  - the datapath side: drives opcode and mem_ready, takes the strobes
// Signals:
//   opcode[5:0]    IR[31:26], stable from DECODE until the return to FETCH
//   mem_ready      memory access completes this cycle
//   PCWrite, PCWriteCond, branch_ne       PC update controls
//   IorD, MemRead, MemWrite, IRWrite      memory / IR controls
//   MemtoReg, RegDst, RegWrite            register file controls
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]     ALU operand / operation select
//   PCSource[1:0]  next-PC source select
//   illegal_op     one-cycle pulse on an unrecognised opcode in DECODE
//   state[3:0]     current FSM state code (debug)
interface unidade_controle_multiciclo_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       branch_ne;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Purpose: multi-cycle MIPS main control FSM. Sequences the shared datapath
//          (single memory, single ALU, IR, ALUOut/MDR) through FETCH, DECODE,
//          EXEC, MEM and WB steps for R-type, LW, SW, BEQ, J and ADDI, with a
//          mem_ready handshake that stalls FETCH, MEMRD and MEMWR.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset; forces state=FETCH and all
//          control outputs to 0 while asserted
//   bus  - unidade_controle_multiciclo_if.master (opcode, mem_ready in;
//          datapath control strobes, illegal_op, state out)
// Parameters:
//   MEM_WAIT_EN_DEFAULT - 1: honour mem_ready; 0: memory treated as always ready
// Optional feature:
//   CONTROLE_BNE_EN - when defined, opcode 000101 (BNE) branches through
//                     BRANCH with branch_ne=1 instead of PCWriteCond.
// Outputs are Moore-decoded from the state register; the exceptions are
// IRWrite/PCWrite in FETCH (gated by mem_ready) and illegal_op (opcode in DECODE).
module unidade_controle_multiciclo #(
  parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
  input logic clk,
  input logic rst,
  unidade_controle_multiciclo_if.master bus
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`ifdef CONTROLE_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       br_ne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;

  // Memory handshake, optionally bypassed for zero-wait memories
  assign ready = MEM_WAIT_EN_DEFAULT ? bus.mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    br_ne         = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        // PC+4 is computed every cycle but only committed with the IR load
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ready;
        pc_write  = ready;
        state_d   = ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Speculative branch target into ALUOut
        alu_src_b = SRCB_IMM2;
        case (bus.opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDIEX;
`ifdef CONTROLE_BNE_EN
          OP_BNE:        state_d = BRANCH;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        // Write strobe held for the whole wait so slow memory sees a stable request
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
`ifdef CONTROLE_BNE_EN
        if (bus.opcode == OP_BNE) begin
          br_ne = 1'b1;
        end else begin
          pc_write_cond = 1'b1;
        end
`else
        pc_write_cond = 1'b1;
`endif
        state_d = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        state_d   = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset silences the datapath immediately, even mid-instruction
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      br_ne         = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCS_ALU;
      illegal       = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.branch_ne   = br_ne;
  assign bus.IorD        = i_or_d;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.PCSource    = pc_source;
  assign bus.illegal_op  = illegal;
  assign bus.state       = 4'(state_q);

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Purpose: directed self-checking bench for unidade_controle_multiciclo.
// Each scenario task drives opcode/mem_ready cycle by cycle and compares the
// state code plus the packed control word against hand-derived constants.
// Control word bit order (18 bits, MSB first):
//   PCWrite PCWriteCond branch_ne IorD MemRead MemWrite IRWrite MemtoReg
//   RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
module tb_unidade_controle_multiciclo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  unidade_controle_multiciclo_if bus ();

  unidade_controle_multiciclo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  //                                   PW PWC BNE IoD MR MW IRW M2R RD RW SA SB  OP  PCS ILL
  localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_FETCH_R  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_FETCH_W  = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_MEMRD    = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] C_MEMWR    = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_EXEC     = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [17:0] C_ALUWB    = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] C_BEQ      = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_ADDIEX   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_ADDIWB   = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
`ifdef CONTROLE_BNE_EN
  localparam logic [17:0] C_BNE      = 18'b0_0_1_0_0_0_0_0_0_0_1_00_01_01_0;
`endif

  function automatic logic [17:0] ctl();
    return {bus.PCWrite, bus.PCWriteCond, bus.branch_ne, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
  endfunction

  task automatic test_reset();
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_FETCH_R) begin
      errors++;
      $display("FAIL reset_first_fetch: state=%0d ctl=%b expected state=0 ctl=%b", bus.state, ctl(), C_FETCH_R);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd6 || ctl() !== C_EXEC) begin
      errors++;
      $display("FAIL reset_reach_exec: state=%0d ctl=%b expected state=6 ctl=%b", bus.state, ctl(), C_EXEC);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_ZERO) begin
      errors++;
      $display("FAIL reset_async_drop: state=%0d ctl=%b expected state=0 ctl=%b", bus.state, ctl(), C_ZERO);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_ZERO) begin
      errors++;
      $display("FAIL reset_held: state=%0d ctl=%b expected state=0 ctl=%b", bus.state, ctl(), C_ZERO);
    end
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_FETCH_W) begin
      errors++;
      $display("FAIL reset_release_fetch: state=%0d ctl=%b expected state=0 ctl=%b", bus.state, ctl(), C_FETCH_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_fetch_wait();
    logic [3:0]  es [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [17:0] ec [8] = '{C_FETCH_W, C_FETCH_W, C_FETCH_W, C_FETCH_R,
                            C_DECODE, C_EXEC, C_ALUWB, C_FETCH_W};
    logic        rd [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL rtype_fetch_wait cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [17:0] ec [8] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD,
                            C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH_W};
    logic        rd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL lw_wait cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    logic [17:0] ec [6] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_FETCH_W};
    logic        rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL sw_wait cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // BEQ immediately followed by J, no idle cycle in between
  task automatic test_back_to_back();
    logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd11, 4'd0};
    logic [17:0] ec [7] = '{C_FETCH_R, C_DECODE, C_BEQ, C_FETCH_R, C_DECODE, C_JUMP, C_FETCH_W};
    logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  op [7] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010,
                            6'b000010, 6'b000010, 6'b000010};
    for (int i = 0; i < 7; i++) begin
      bus.opcode    = op[i];
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL beq_j cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [17:0] ec [5] = '{C_FETCH_R, C_DECODE, C_ADDIEX, C_ADDIWB, C_FETCH_W};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL addi cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd0};
    logic [17:0] ec [3] = '{C_FETCH_R, C_DEC_ILL, C_FETCH_W};
    logic        rd [3] = '{1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
`ifdef CONTROLE_BNE_EN
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [17:0] ec [4] = '{C_FETCH_R, C_DECODE, C_BNE, C_FETCH_W};
    logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam int N = 4;
`else
    logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd0};
    logic [17:0] ec [3] = '{C_FETCH_R, C_DEC_ILL, C_FETCH_W};
    logic        rd [3] = '{1'b1, 1'b1, 1'b0};
    localparam int N = 3;
`endif
    bus.opcode = 6'b000101;
    for (int i = 0; i < N; i++) begin
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        errors++;
        $display("FAIL bne cyc%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, bus.state, ctl(), es[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_ZERO) begin
      errors++;
      $display("FAIL power_on_reset: state=%0d ctl=%b expected state=0 ctl=%b", bus.state, ctl(), C_ZERO);
    end
    rst = 1'b0;

    test_reset();
    test_rtype_fetch_wait();
    test_lw_wait();
    test_sw_wait();
    test_back_to_back();
    test_addi();
    test_illegal();
    test_bne();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
Multi-cycle MIPS main control FSM; sequences the shared datapath (one memory, one ALU, IR, ALUOut/MDR registers) across FETCH/DECODE/EXEC/MEM/WB steps.
- Replaces per-opcode single-cycle decode for the multi-cycle core.
- Same opcode set: R-type, LW, SW, BEQ, J, ADDI.
- Adds a memory-ready handshake so slow memory stalls the sequence.

Parameters:
MEM_WAIT_EN_DEFAULT, 1, 1 = honour mem_ready; 0 = treat memory as always ready (mem_ready ignored).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26], stable from DECODE until return to FETCH
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU zero (BEQ)
branch_ne  output  1  PC write if ALU not zero (only with optional feature; else 0)
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read
MemWrite  output  1  memory write
IRWrite  output  1  load IR
MemtoReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination: 0 = rt, 1 = rd
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse: unrecognised opcode in DECODE
state  output  4  current state code (debug)

Behaviour:
- Moore outputs decoded from state; the only exceptions are the mem_ready gating and illegal_op, noted below.
- Any output not listed for a state = 0.
- Reset: while rst = 1, state = FETCH (0) and every output = 0, combinationally forced. First FETCH activity is on the first edge after rst deasserts.
- States (code: name, outputs -> next):
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite = PCWrite = mem_ready. Stay until mem_ready -> DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
    - 000000 -> EXEC
    - 100011 / 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - else -> FETCH with illegal_op=1 this cycle
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if opcode 100011, else MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1; hold until mem_ready -> MEMWB.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - 5 MEMWR: MemWrite=1, IorD=1; hold (MemWrite stays 1) until mem_ready -> FETCH.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - 7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - 10 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - 11 JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - 12-15 unreachable; next state = FETCH, outputs 0.
- Latency with zero-wait memory, cycles per instruction: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2.
- Each wait cycle on mem_ready adds 1 cycle in FETCH, MEMRD or MEMWR.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- With MEM_WAIT_EN_DEFAULT=0, mem_ready is treated as constant 1.
- Reset mid-instruction (any state, including memory wait): outputs drop to 0 immediately; restart at FETCH.

Optional Feature:
CONTROLE_BNE_EN
- Defined: opcode 000101 in DECODE -> BRANCH. In BRANCH for that opcode, branch_ne=1 and PCWriteCond=0 (ALU sub, PCSource=01 unchanged). BNE CPI = 3.
- Undefined: branch_ne tied 0; 000101 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- Reset: assert rst in EXEC, then release -> all outputs 0 during reset; state=0 after; first FETCH has MemRead=1.
- R-type 000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7.
- LW 100011 with 2 wait cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 throughout state 3; MemtoReg=1 in 4.
- FETCH with mem_ready low 3 cycles -> IRWrite=PCWrite=0 for 3 cycles, then 1 for one cycle; DECODE next.
- BEQ 000100 then J 000010 -> state 8: PCWriteCond=1, ALUOp=01, PCSource=01; state 11: PCWrite=1, PCSource=10; each 3 cycles.
- Opcode 111111 -> illegal_op=1 in DECODE only, back to FETCH. Opcode 000101 -> same pulse without the macro; with CONTROLE_BNE_EN, state 8 with branch_ne=1.
